// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared helpers for the reg_pipe register pipeline.
//   clog2_p1(n)         : bits needed to hold a count in the range 0..n
//   params_ok(w, d)     : elaboration-time sanity check of WIDTH / DEPTH
package reg_pipe_pkg;

    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit params_ok(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one pipeline slice holding a valid bit and a data word.
//   clk, rst  : clock, synchronous active-high reset (v=0, d=RST_VAL)
//   flush     : clears v, leaves d untouched
//   load      : capture d_in and mark the slice valid
//   clr_v     : slice contents moved on; drop valid unless reloaded
//   d_in      : incoming data word
//   v_q, d_q  : registered valid and data
module reg_pipe_stage #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             clr_v,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_q,
    output logic [WIDTH-1:0] d_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (load) begin
            v_q <= 1'b1;
        end else if (clr_v) begin
            v_q <= 1'b0;
        end
    end

    // Data only moves on a real transfer, so an empty slice never
    // captures garbage and a flush leaves the last word in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else if (load && !flush) begin
            d_q <= d_in;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow
// control, bubble collapse, synchronous flush and an occupancy counter.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : clear all stage valids on the next edge
//   in_valid/in_ready   : upstream handshake, in_data captured into stage 0
//   out_valid/out_ready : downstream handshake, out_data = last stage register
//   occupancy           : number of valid stages, 0..DEPTH
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              OCC_W   = clog2_p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (!params_ok(WIDTH, DEPTH)) begin : g_param_check
        $error("reg_pipe: WIDTH and DEPTH must both be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_hs;
    logic             out_hs;

    // Advance chain runs from the output back to the input: a stage moves
    // when the one in front is empty or is itself moving, which is what
    // collapses bubbles. This makes in_ready combinational from out_ready.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign in_ready  = ~flush & (~v[0] | adv[0]);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = v[DEPTH-1] & out_ready;

    // Stage i+1 loads exactly when stage i advances into it.
    always_comb begin
        load    = '0;
        load[0] = in_hs;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;

        if (i == 0) begin : g_head
            assign d_in = in_data;
        end else begin : g_body
            assign d_in = d[i-1];
        end

        reg_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .load  (load[i]),
            .clr_v (adv[i]),
            .d_in  (d_in),
            .v_q   (v[i]),
            .d_q   (d[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (in_hs && !out_hs) begin
            occupancy <= occupancy + 1'b1;
        end else if (!in_hs && out_hs) begin
            occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: self-checking bench for reg_pipe. A DEPTH=4 instance is
// tracked by a queue-of-words reference model; a DEPTH=1 instance is
// exercised with directed checks.
module tb_reg_pipe;

    localparam int         D   = 4;
    localparam logic [7:0] RV4 = 8'hA5;
    localparam logic [7:0] RV1 = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    logic       r1, f1, iv1, or1;
    logic [7:0] id1;
    logic       ir1, ov1;
    logic [7:0] od1;
    logic [0:0] oc1;

    int n_tests = 0;
    int n_fail  = 0;

    reg_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV1)) u_dut1 (
        .clk(clk), .rst(r1), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1)
    );

    // Reference model: words in flight, oldest first, each with the stage
    // index it currently occupies. A word moves one stage per edge unless
    // the word ahead of it blocks.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } word_t;

    word_t      mq[$];
    logic [7:0] m_last = RV4;

    function automatic bit m_in_ready();
        return !flush && ((mq.size() < D) || out_ready);
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].pos == D - 1);
    endfunction

    task automatic model_edge();
        bit    ihs, ohs;
        int    prev, np;
        word_t w;
        ihs = in_valid && m_in_ready();
        ohs = m_out_valid() && out_ready;
        if (rst) begin
            mq.delete();
            m_last = RV4;
            return;
        end
        if (flush) begin
            mq.delete();
            return;
        end
        if (ohs) void'(mq.pop_front());
        prev = D;
        foreach (mq[j]) begin
            np = (mq[j].pos + 1 < prev - 1) ? mq[j].pos + 1 : prev - 1;
            if (np == D - 1 && mq[j].pos != D - 1) m_last = mq[j].data;
            mq[j].pos = np;
            prev      = np;
        end
        if (ihs) begin
            w.data = in_data;
            w.pos  = 0;
            mq.push_back(w);
            if (D == 1) m_last = in_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_data !== RV4) begin n_fail++; $display("FAIL reset_out_data got %h want %h", out_data, RV4); end
        n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        bit exp_v;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            in_valid  = (c < 10);
            in_data   = 8'(c + 1);
            out_ready = 1'b1;
            #1;
            if (c < 10) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc %0d got %b want 1", c, in_ready); end
            end
            exp_v = (c >= 4) && (c <= 13);
            n_tests++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_out_valid cyc %0d got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_tests++; if (out_data !== 8'(c - 3)) begin n_fail++; $display("FAIL stream_out_data cyc %0d got %h want %h", c, out_data, 8'(c - 3)); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit   exp_r, sent;
        int   next_w, exp_w;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(c + 1);
            #1;
            exp_r = (c < 4);
            n_tests++; if (in_ready !== exp_r) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want %b", c, in_ready, exp_r); end
            if (c >= 4) begin
                n_tests++; if (out_data !== 8'd1) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h want 01", c, out_data); end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_full_occ got %0d want 4", occupancy); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        next_w = 5;
        exp_w  = 1;
        for (int c = 0; c < 12; c++) begin
            out_ready = 1'b1;
            in_valid  = (next_w <= 6);
            in_data   = 8'(next_w);
            #1;
            if (c == 0) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_pass_ready got %b want 1", in_ready); end
            end
            if (out_valid === 1'b1) begin
                n_tests++; if (out_data !== 8'(exp_w)) begin n_fail++; $display("FAIL bp_drain_data got %h want %h", out_data, 8'(exp_w)); end
                exp_w++;
            end
            sent = in_valid && (in_ready === 1'b1);
            tick();
            if (sent) next_w++;
            if (c == 0) begin
                n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_simul_occ got %0d want 4", occupancy); end
            end
        end
        n_tests++; if (exp_w !== 7) begin n_fail++; $display("FAIL bp_drain_count got %0d want 6", exp_w - 1); end
        in_valid = 1'b0;
    endtask

    task automatic test_bubble_collapse();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0) || (c == 3);
            in_data  = (c == 0) ? 8'h11 : 8'h22;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL bubble_occ got %0d want 2", occupancy); end
        n_tests++; if (u_dut4.v !== 4'b1100) begin n_fail++; $display("FAIL bubble_valids got %b want 1100", u_dut4.v); end
        n_tests++; if (u_dut4.d[3] !== 8'h11) begin n_fail++; $display("FAIL bubble_stage3 got %h want 11", u_dut4.d[3]); end
        n_tests++; if (u_dut4.d[2] !== 8'h22) begin n_fail++; $display("FAIL bubble_stage2 got %h want 22", u_dut4.d[2]); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(c + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
        in_valid = 1'b1; in_data = 8'h77; flush = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_valid cyc %0d got %b want 0", c, out_valid); end
            tick();
        end
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0);
            in_data  = 8'h55;
            #1;
            n_tests++; if (out_valid !== (c == 4)) begin n_fail++; $display("FAIL flush_repush_valid cyc %0d got %b want %b", c, out_valid, (c == 4)); end
            if (out_valid === 1'b1) begin
                n_tests++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL flush_repush_data got %h want 55", out_data); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_depth1();
        r1 = 1'b1; f1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        tick();
        tick();
        r1 = 1'b0;
        #1;
        n_tests++; if (od1 !== RV1) begin n_fail++; $display("FAIL d1_reset_data got %h want %h", od1, RV1); end
        n_tests++; if (ov1 !== 1'b0 || oc1 !== 1'b0) begin n_fail++; $display("FAIL d1_reset_valid_occ got %b/%0d want 0/0", ov1, oc1); end
        n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL d1_reset_ready got %b want 1", ir1); end
        iv1 = 1'b1; id1 = 8'h10;
        tick();
        id1 = 8'h99;
        #1;
        n_tests++; if (ov1 !== 1'b1 || od1 !== 8'h10 || oc1 !== 1'b1) begin n_fail++; $display("FAIL d1_load got v%b d%h o%0d want v1 d10 o1", ov1, od1, oc1); end
        n_tests++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL d1_full_stall_ready got %b want 0", ir1); end
        or1 = 1'b1; id1 = 8'h20;
        #1;
        n_tests++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL d1_pass_ready got %b want 1", ir1); end
        tick();
        iv1 = 1'b0; or1 = 1'b0;
        #1;
        n_tests++; if (ov1 !== 1'b1 || od1 !== 8'h20 || oc1 !== 1'b1) begin n_fail++; $display("FAIL d1_pass got v%b d%h o%0d want v1 d20 o1", ov1, od1, oc1); end
        f1 = 1'b1;
        #1;
        n_tests++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL d1_flush_ready got %b want 0", ir1); end
        tick();
        f1 = 1'b0;
        #1;
        n_tests++; if (ov1 !== 1'b0 || od1 !== 8'h20 || oc1 !== 1'b0) begin n_fail++; $display("FAIL d1_flush got v%b d%h o%0d want v0 d20 o0", ov1, od1, oc1); end
        iv1 = 1'b1; id1 = 8'h44;
        tick();
        iv1 = 1'b0;
        #1;
        n_tests++; if (ov1 !== 1'b1 || od1 !== 8'h44) begin n_fail++; $display("FAIL d1_refill got v%b d%h want v1 d44", ov1, od1); end
        r1 = 1'b1; f1 = 1'b1; iv1 = 1'b1; id1 = 8'h66;
        tick();
        r1 = 1'b0; f1 = 1'b0; iv1 = 1'b0;
        #1;
        n_tests++; if (ov1 !== 1'b0 || od1 !== RV1 || oc1 !== 1'b0) begin n_fail++; $display("FAIL d1_rst_over_flush got v%b d%h o%0d want v0 d%h o0", ov1, od1, oc1, RV1); end
    endtask

    task automatic test_random();
        bit         e_r, e_v;
        logic [2:0] e_o;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            #1;
            e_r = m_in_ready();
            e_v = m_out_valid();
            e_o = 3'(mq.size());
            n_tests++; if (in_ready !== e_r) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, e_r); end
            n_tests++; if (out_valid !== e_v) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", c, out_valid, e_v); end
            n_tests++; if (out_data !== m_last) begin n_fail++; $display("FAIL rnd_out_data cyc %0d got %h want %h", c, out_data, m_last); end
            n_tests++; if (occupancy !== e_o) begin n_fail++; $display("FAIL rnd_occupancy cyc %0d got %0d want %0d", c, occupancy, e_o); end
            n_tests++; if (occupancy !== 3'($countones(u_dut4.v))) begin n_fail++; $display("FAIL rnd_occ_popcount cyc %0d got %0d want %0d", c, occupancy, $countones(u_dut4.v)); end
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        r1  = 1'b1; f1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble_collapse();
        test_flush();
        test_depth1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
